game_state_controller: RTL and testbench
========================================

# game_state_controller

- Sequential controller that produces the 2-bit `game_state_code` consumed by the game-state decoder. It is the encoding end of that interface.
- Sequences one match through off, preparation (ship placement), attack and game-over, and keeps the placement, shot and hit counters that drive those transitions.
- Sits between the player input logic (buttons and switches, placement and shot pulses) and all enable-gated datapath blocks.

## Interface
Parameters:
- `NUM_SHIPS`, 4: ships that must be placed before attack is allowed (1..15).
- `HIT_TARGET`, 8: total ship cells that must be hit to win (1..255).
- `MAX_SHOTS`, 16: shot budget per match (1..255).

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `power_sw`  in  1  level; 0 forces OFF.
- `confirm`  in  1  debounced button level; acts on its rising edge only.
- `ship_placed`  in  1  one-cycle pulse from the placement logic.
- `shot_valid`  in  1  one-cycle pulse; a shot was fired.
- `shot_hit`  in  1  qualifies `shot_valid`; the shot hit a ship cell.
- `game_state_code`  out  2  00 off/game-over, 01 preparation, 10 attack; 11 is never driven.
- `ships_placed`  out  4  ships placed in the current match.
- `hits`  out  8  hits in the current match.
- `shots_left`  out  8  remaining shot budget.
- `game_over`  out  1  high in the END state.
- `player_won`  out  1  valid while `game_over`=1.

## Operation
- Internal states and their `game_state_code`: OFF=00, PREP=01, ATTACK=10, END=00 (with `game_over`=1).
- `confirm_rise` = `confirm` & ~`confirm_q`, where `confirm_q` is a register on `confirm`.
- Highest priority, any state: `power_sw`=0 → OFF. Counters clear, `game_over` and `player_won` clear.
- OFF: `power_sw`=1 and `confirm_rise` → PREP. `ships_placed`=0, `hits`=0, `shots_left`=MAX_SHOTS.
- PREP:
  - `ship_placed` increments `ships_placed`, saturating at NUM_SHIPS. Extra pulses are ignored.
  - `confirm_rise` with `ships_placed`==NUM_SHIPS → ATTACK.
  - `confirm_rise` with fewer ships is ignored; state stays PREP.
  - A `ship_placed` pulse in the same cycle as a `confirm_rise` counts first. The confirm then takes effect if the updated count equals NUM_SHIPS.
- ATTACK:
  - `shot_valid` decrements `shots_left` and, if `shot_hit`=1, increments `hits`.
  - `shot_hit` without `shot_valid` is ignored.
  - `confirm_rise` is ignored.
  - Next-hit count == HIT_TARGET → END, `player_won`=1.
  - Otherwise, next `shots_left` == 0 → END, `player_won`=0.
  - A winning hit on the last shot counts as a win.
- END: `shot_valid`, `shot_hit` and `ship_placed` are ignored. Counters hold their final values. `confirm_rise` → PREP with counters cleared as on the OFF→PREP entry.
- Pulses arriving in a state that does not use them are dropped, not queued.

## Timing
- All outputs are registered, with no combinational input→output paths.
- Reset values: `game_state_code`=00, `ships_placed`=0, `hits`=0, `shots_left`=MAX_SHOTS, `game_over`=0, `player_won`=0, `confirm_q`=0.
- Latency: a qualifying event sampled at rising edge k is visible on all outputs after edge k. This covers a rising edge of `confirm`, a pulse, or `power_sw` low.
- `confirm` held high produces exactly one `confirm_rise`. A new rise needs at least one low sample.
- `rst_n` asserted mid-match clears everything immediately and asynchronously. `rst_n` is released synchronously upstream, and the first edge after release evaluates normally.
- Counters never wrap: `ships_placed` saturates, `shots_left` stops at 0 (END is entered), `hits` stops at HIT_TARGET.

## Configuration
- `GAME_CONFIRM_SYNC_EN` defined: `confirm` first passes a 2-flop synchronizer ahead of `confirm_q`. Confirm-driven transitions then appear 2 cycles later (edge k+2). All other paths are unchanged. Synchronizer flops reset to 0.
- `GAME_CONFIRM_SYNC_EN` undefined: `confirm` feeds `confirm_q` directly. `confirm` must already be synchronous to `clk`.

## Test plan
- Reset, `power_sw`=1, confirm pulse → `game_state_code` 00→01 one edge later. `shots_left`=16, `ships_placed`=0.
- PREP with 3 `ship_placed` pulses, then confirm → stays 01. Fourth pulse, then confirm → 10. A fifth pulse earlier leaves `ships_placed`=4.
- ATTACK with 8 `shot_valid`+`shot_hit` pulses → `hits`=8, `game_over`=1, `player_won`=1, code 00, `shots_left`=8.
- ATTACK with 16 misses → `shots_left`=0, `game_over`=1, `player_won`=0. Further `shot_valid` pulses → no change.
- 7 hits plus 8 misses, then a 16th shot that hits → `player_won`=1 (win priority). Then confirm → PREP, counters cleared.
- `power_sw` dropped mid-ATTACK → OFF next edge, all counters reset. `rst_n` low mid-PREP → outputs at reset values asynchronously. With `GAME_CONFIRM_SYNC_EN`, the confirm transition occurs at edge k+2.

Source files
------------

// File: rtl/game_state_controller_if.sv
// ============================================================================
// game_state_controller_if
// Player-input / game-status bundle between the input logic and the controller.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface game_state_controller_if;
  logic       power_sw;
  logic       confirm;
  logic       ship_placed;
  logic       shot_valid;
  logic       shot_hit;
  logic [1:0] game_state_code;
  logic [3:0] ships_placed;
  logic [7:0] hits;
  logic [7:0] shots_left;
  logic       game_over;
  logic       player_won;

  // Player input side
  modport master (
    output power_sw, confirm, ship_placed, shot_valid, shot_hit,
    input  game_state_code, ships_placed, hits, shots_left, game_over, player_won
  );

  // Controller side
  modport slave (
    input  power_sw, confirm, ship_placed, shot_valid, shot_hit,
    output game_state_code, ships_placed, hits, shots_left, game_over, player_won
  );
endinterface

`default_nettype wire

// File: rtl/game_state_controller.sv
// ============================================================================
// game_state_controller
// Match sequencer OFF -> PREP -> ATTACK -> END, with placement/shot/hit counters.
// Optional: GAME_CONFIRM_SYNC_EN inserts a 2-flop synchronizer on confirm.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module game_state_controller #(
  parameter int NUM_SHIPS  = 4,
  parameter int HIT_TARGET = 8,
  parameter int MAX_SHOTS  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  game_state_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_PREP   = 2'd1,
    S_ATTACK = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam logic [3:0] C_NUM_SHIPS  = 4'(NUM_SHIPS);
  localparam logic [7:0] C_HIT_TARGET = 8'(HIT_TARGET);
  localparam logic [7:0] C_MAX_SHOTS  = 8'(MAX_SHOTS);

  state_t     state_q;
  logic [1:0] code_q;
  logic [3:0] ships_q, ships_d;
  logic [7:0] hits_q, hits_d;
  logic [7:0] shots_q, shots_d;
  logic       over_q;
  logic       won_q;
  logic       confirm_q;
  logic       confirm_s;
  logic       confirm_rise;

`ifdef GAME_CONFIRM_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.confirm;
      sync2_q <= sync1_q;
    end
  end

  assign confirm_s = sync2_q;
`else
  assign confirm_s = bus.confirm;
`endif

  assign confirm_rise = confirm_s & ~confirm_q;

  // Candidate counter values; the FSM decides which state may commit them.
  always_comb begin
    ships_d = ships_q;
    hits_d  = hits_q;
    shots_d = shots_q;
    if (bus.ship_placed && (ships_q != C_NUM_SHIPS))
      ships_d = ships_q + 4'd1;
    if (bus.shot_valid && (shots_q != 8'd0)) begin
      shots_d = shots_q - 8'd1;
      if (bus.shot_hit && (hits_q != C_HIT_TARGET))
        hits_d = hits_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_OFF;
      code_q    <= 2'b00;
      ships_q   <= 4'd0;
      hits_q    <= 8'd0;
      shots_q   <= C_MAX_SHOTS;
      over_q    <= 1'b0;
      won_q     <= 1'b0;
      confirm_q <= 1'b0;
    end else begin
      confirm_q <= confirm_s;
      if (!bus.power_sw) begin
        state_q <= S_OFF;
        code_q  <= 2'b00;
        ships_q <= 4'd0;
        hits_q  <= 8'd0;
        shots_q <= C_MAX_SHOTS;
        over_q  <= 1'b0;
        won_q   <= 1'b0;
      end else begin
        case (state_q)
          S_OFF, S_END: begin
            if (confirm_rise) begin
              state_q <= S_PREP;
              code_q  <= 2'b01;
              ships_q <= 4'd0;
              hits_q  <= 8'd0;
              shots_q <= C_MAX_SHOTS;
              over_q  <= 1'b0;
              won_q   <= 1'b0;
            end
          end
          S_PREP: begin
            ships_q <= ships_d;
            // A placement in the same cycle counts before the confirm is judged.
            if (confirm_rise && (ships_d == C_NUM_SHIPS)) begin
              state_q <= S_ATTACK;
              code_q  <= 2'b10;
            end
          end
          S_ATTACK: begin
            if (bus.shot_valid) begin
              hits_q  <= hits_d;
              shots_q <= shots_d;
              if (hits_d == C_HIT_TARGET) begin
                state_q <= S_END;
                code_q  <= 2'b00;
                over_q  <= 1'b1;
                won_q   <= 1'b1;
              end else if (shots_d == 8'd0) begin
                state_q <= S_END;
                code_q  <= 2'b00;
                over_q  <= 1'b1;
                won_q   <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= S_OFF;
            code_q  <= 2'b00;
          end
        endcase
      end
    end
  end

  assign bus.game_state_code = code_q;
  assign bus.ships_placed    = ships_q;
  assign bus.hits            = hits_q;
  assign bus.shots_left      = shots_q;
  assign bus.game_over       = over_q;
  assign bus.player_won      = won_q;

endmodule

`default_nettype wire

// File: tb/tb_game_state_controller.sv
// ============================================================================
// tb_game_state_controller
// Directed scoreboard bench: stimulus queues expected outputs, monitor compares.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_state_controller;

`ifdef GAME_CONFIRM_SYNC_EN
  localparam int CONF_LAT = 2;
`else
  localparam int CONF_LAT = 0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  game_state_controller_if gif ();

  game_state_controller #(
    .NUM_SHIPS  (4),
    .HIT_TARGET (8),
    .MAX_SHOTS  (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [1:0] code;
    logic [3:0] ships;
    logic [7:0] hits;
    logic [7:0] shots;
    logic       over;
    logic       won;
  } exp_t;

  exp_t sb[$];

  task automatic expect_o(input string nm, input logic [1:0] c, input logic [3:0] s,
                          input logic [7:0] h, input logic [7:0] sl,
                          input logic go, input logic pw);
    exp_t e;
    e.nm = nm; e.code = c; e.ships = s; e.hits = h; e.shots = sl; e.over = go; e.won = pw;
    sb.push_back(e);
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (gif.game_state_code !== e.code || gif.ships_placed !== e.ships ||
          gif.hits !== e.hits || gif.shots_left !== e.shots ||
          gif.game_over !== e.over || gif.player_won !== e.won) begin
        bad++;
        $display("FAIL %s: got code=%0d ships=%0d hits=%0d shots=%0d over=%0d won=%0d, want code=%0d ships=%0d hits=%0d shots=%0d over=%0d won=%0d",
                 e.nm, gif.game_state_code, gif.ships_placed, gif.hits, gif.shots_left,
                 gif.game_over, gif.player_won, e.code, e.ships, e.hits, e.shots, e.over, e.won);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic place();
    gif.ship_placed = 1'b1;
    tick();
    gif.ship_placed = 1'b0;
  endtask

  task automatic shot(input logic hit);
    gif.shot_valid = 1'b1;
    gif.shot_hit   = hit;
    tick();
    gif.shot_valid = 1'b0;
    gif.shot_hit   = 1'b0;
  endtask

  // Returns just after the edge on which the confirm should take effect.
  task automatic do_confirm();
    gif.confirm = 1'b1;
    tick();
    gif.confirm = 1'b0;
    repeat (CONF_LAT) tick();
  endtask

  task automatic enter_attack();
    do_confirm();
    expect_o("end_to_prep", 2'b01, 4'd0, 8'd0, 8'd16, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      place();
      expect_o("place", 2'b01, 4'(i), 8'd0, 8'd16, 1'b0, 1'b0);
    end
    do_confirm();
    expect_o("prep_to_attack", 2'b10, 4'd4, 8'd0, 8'd16, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    gif.power_sw = 1'b0; gif.confirm = 1'b0; gif.ship_placed = 1'b0;
    gif.shot_valid = 1'b0; gif.shot_hit = 1'b0;
    tick(); tick();
    expect_o("reset", 2'b00, 4'd0, 8'd0, 8'd16, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    gif.power_sw = 1'b1;
    tick();
    expect_o("off_idle", 2'b00, 4'd0, 8'd0, 8'd16, 1'b0, 1'b0);

    do_confirm();
    expect_o("off_to_prep", 2'b01, 4'd0, 8'd0, 8'd16, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      place();
      expect_o("place3", 2'b01, 4'(i), 8'd0, 8'd16, 1'b0, 1'b0);
    end
    do_confirm();
    expect_o("confirm_short", 2'b01, 4'd3, 8'd0, 8'd16, 1'b0, 1'b0);
    place();
    expect_o("place4", 2'b01, 4'd4, 8'd0, 8'd16, 1'b0, 1'b0);
    place();
    expect_o("place_sat", 2'b01, 4'd4, 8'd0, 8'd16, 1'b0, 1'b0);
    do_confirm();
    expect_o("to_attack", 2'b10, 4'd4, 8'd0, 8'd16, 1'b0, 1'b0);

    do_confirm();
    expect_o("attack_conf_ign", 2'b10, 4'd4, 8'd0, 8'd16, 1'b0, 1'b0);
    gif.shot_hit = 1'b1;
    tick();
    gif.shot_hit = 1'b0;
    expect_o("hit_no_valid", 2'b10, 4'd4, 8'd0, 8'd16, 1'b0, 1'b0);

    for (int i = 1; i <= 8; i++) begin
      shot(1'b1);
      if (i < 8) expect_o("hit_run", 2'b10, 4'd4, 8'(i), 8'(16 - i), 1'b0, 1'b0);
      else       expect_o("win8", 2'b00, 4'd4, 8'd8, 8'd8, 1'b1, 1'b1);
    end
    shot(1'b1);
    expect_o("end_shot_ign", 2'b00, 4'd4, 8'd8, 8'd8, 1'b1, 1'b1);
    place();
    expect_o("end_place_ign", 2'b00, 4'd4, 8'd8, 8'd8, 1'b1, 1'b1);

    // Second match: the last placement coincides with the confirm when unsynchronized.
    do_confirm();
    expect_o("end_to_prep", 2'b01, 4'd0, 8'd0, 8'd16, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      place();
      expect_o("place_m2", 2'b01, 4'(i), 8'd0, 8'd16, 1'b0, 1'b0);
    end
    if (CONF_LAT == 0) begin
      gif.ship_placed = 1'b1;
      gif.confirm     = 1'b1;
      tick();
      gif.ship_placed = 1'b0;
      gif.confirm     = 1'b0;
    end else begin
      place();
      do_confirm();
    end
    expect_o("place_and_conf", 2'b10, 4'd4, 8'd0, 8'd16, 1'b0, 1'b0);

    for (int i = 1; i <= 16; i++) begin
      shot(1'b0);
      if (i < 16) expect_o("miss_run", 2'b10, 4'd4, 8'd0, 8'(16 - i), 1'b0, 1'b0);
      else        expect_o("lose", 2'b00, 4'd4, 8'd0, 8'd0, 1'b1, 1'b0);
    end
    shot(1'b0);
    expect_o("lose_hold", 2'b00, 4'd4, 8'd0, 8'd0, 1'b1, 1'b0);

    enter_attack();
    for (int i = 1; i <= 7; i++) begin
      shot(1'b1);
      expect_o("mix_hit", 2'b10, 4'd4, 8'(i), 8'(16 - i), 1'b0, 1'b0);
    end
    for (int j = 1; j <= 8; j++) begin
      shot(1'b0);
      expect_o("mix_miss", 2'b10, 4'd4, 8'd7, 8'(9 - j), 1'b0, 1'b0);
    end
    shot(1'b1);
    expect_o("last_shot_win", 2'b00, 4'd4, 8'd8, 8'd0, 1'b1, 1'b1);

    enter_attack();
    shot(1'b1);
    expect_o("pre_power", 2'b10, 4'd4, 8'd1, 8'd15, 1'b0, 1'b0);
    gif.power_sw = 1'b0;
    tick();
    expect_o("power_off", 2'b00, 4'd0, 8'd0, 8'd16, 1'b0, 1'b0);
    gif.power_sw = 1'b1;
    tick();

    do_confirm();
    expect_o("repower_prep", 2'b01, 4'd0, 8'd0, 8'd16, 1'b0, 1'b0);
    place();
    expect_o("prep_one", 2'b01, 4'd1, 8'd0, 8'd16, 1'b0, 1'b0);
    tick();
    // Reset between edges: checked at the next falling edge, before any rising edge.
    rst_n = 1'b0;
    expect_o("async_reset", 2'b00, 4'd0, 8'd0, 8'd16, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
